// File: rtl/xy_pkg.sv
// Shared types and helpers for the XY waypoint sequencer.
// The ERR state exists only when WP_TIMEOUT_EN is defined.
package xy_pkg;

  localparam int BCD_MAX = 9;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_PULSE = 3'd2,
    ST_MOVE  = 3'd3,
    ST_DONE  = 3'd4
`ifdef WP_TIMEOUT_EN
    ,
    ST_ERR   = 3'd5
`endif
  } state_t;

  function automatic logic is_bcd(input logic [7:0] v);
    return (v[7:4] <= 4'(BCD_MAX)) && (v[3:0] <= 4'(BCD_MAX));
  endfunction

endpackage

// File: rtl/wp_fifo.sv
// Waypoint FIFO: power-of-two depth, wrapping pointers, single-cycle flush.
// Flush wins over a coincident push or pop.
module wp_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [W-1:0]             push_data,
  input  logic                     pop,
  output logic [W-1:0]             pop_data,
  input  logic                     flush,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push & ~full & ~flush;
  assign do_pop   = pop & ~empty & ~flush;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage carries data only; occupancy is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/xy_waypoint_seq.sv
// XY waypoint sequencer: queues BCD waypoints and steps a positioner through them.
// Optional arrival watchdog and ERR state enabled by defining WP_TIMEOUT_EN.
module xy_waypoint_seq
  import xy_pkg::*;
#(
  parameter int DEPTH          = 8,
  parameter int MOTION_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wp_valid,
  input  logic [7:0]             wp_data,
  output logic                   wp_ready,
  input  logic                   run,
  input  logic                   flush,
  input  logic [7:0]             pos_in,
  output logic [7:0]             target_out,
  output logic                   motion_out,
  output logic                   busy,
  output logic                   arrived,
  output logic                   wp_err,
  output logic [$clog2(DEPTH):0] count
);

  localparam int MW = (MOTION_CYCLES > 1) ? $clog2(MOTION_CYCLES) : 1;
`ifdef WP_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TW-1:0] tcnt;
`endif

  state_t        state;
  logic [MW-1:0] mcnt;
  logic          match_q;
  logic          init_done;
  logic          fifo_full;
  logic          fifo_empty;
  logic          fifo_flush;
  logic [7:0]    head_data;
  logic          wr_fire;
  logic          wr_ok;
  logic          push;
  logic          pop;

  assign wp_ready = init_done & ~fifo_full;
  assign wr_fire  = wp_valid & wp_ready;
  assign wr_ok    = is_bcd(wp_data);
  assign push     = wr_fire & wr_ok;
  assign pop      = (state == ST_IDLE) & run & ~fifo_empty;

`ifdef WP_TIMEOUT_EN
  assign fifo_flush = flush | (state == ST_ERR);
`else
  assign fifo_flush = flush;
`endif

  wp_fifo #(
    .DEPTH (DEPTH),
    .W     (8)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (wp_data),
    .pop       (pop),
    .pop_data  (head_data),
    .flush     (fifo_flush),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (count)
  );

  // wp_ready stays low until the first edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      init_done <= 1'b0;
      wp_err    <= 1'b0;
    end else begin
      init_done <= 1'b1;
      wp_err    <= wr_fire & ~wr_ok;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      target_out <= 8'h00;
      motion_out <= 1'b0;
      busy       <= 1'b0;
      arrived    <= 1'b0;
      mcnt       <= '0;
      match_q    <= 1'b0;
`ifdef WP_TIMEOUT_EN
      tcnt       <= '0;
`endif
    end else begin
      arrived <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (pop) begin
            target_out <= head_data;
            busy       <= 1'b1;
            state      <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          motion_out <= 1'b1;
          mcnt       <= '0;
          state      <= ST_PULSE;
        end
        ST_PULSE: begin
          if (mcnt == MW'(MOTION_CYCLES - 1)) begin
            motion_out <= 1'b0;
            match_q    <= 1'b0;
`ifdef WP_TIMEOUT_EN
            tcnt       <= '0;
`endif
            state      <= ST_MOVE;
          end else begin
            mcnt <= mcnt + 1'b1;
          end
        end
        ST_MOVE: begin
          // Arrival needs two consecutive matching samples; it wins over a coincident timeout.
          if ((pos_in == target_out) && match_q) begin
            match_q <= 1'b0;
            arrived <= 1'b1;
            state   <= ST_DONE;
          end else begin
            match_q <= (pos_in == target_out);
`ifdef WP_TIMEOUT_EN
            if (tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
              state <= ST_ERR;
            end else begin
              tcnt <= tcnt + 1'b1;
            end
`endif
          end
        end
        ST_DONE: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
`ifdef WP_TIMEOUT_EN
        ST_ERR: begin
          if (flush) begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
        end
`endif
        default: begin
          motion_out <= 1'b0;
          busy       <= 1'b0;
          state      <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
